axi4_masterrd: RTL and testbench
================================

Name: axi4_masterrd

Overview:
AXI4 read initiator. It accepts a local read command (start address, beat count) and splits it into INCR bursts that never cross a 4 KB boundary. It issues the bursts on the AR channel, accepts R beats and forwards them on a local valid/ready stream. This is the master-side counterpart of the AXI4 read slave bridge; it lets local logic fetch from AXI memory in the same single-clock domain.

Parameters:
C_M_AXI_DATA_WIDTH, 32, R data width in bits (power of 2, 32..512)
C_M_AXI_ID_WIDTH, 1, ARID width
C_M_AXI_ADDR_WIDTH, 32, address width
C_M_AXI_ID, 0, constant ARID value
C_MAX_BURST_LEN, 16, maximum beats per burst (1..256)

Ports:
m_axi_aclk  in  1  clock
m_axi_areset  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_addr  in  C_M_AXI_ADDR_WIDTH  start byte address
cmd_len  in  16  total beats (0 = null command)
m_axi_arid  out  C_M_AXI_ID_WIDTH  =C_M_AXI_ID
m_axi_araddr  out  C_M_AXI_ADDR_WIDTH  burst address
m_axi_arlen  out  8  beats-1
m_axi_arsize  out  3  log2(C_M_AXI_DATA_WIDTH/8), constant
m_axi_arburst  out  2  2'b01 INCR, constant
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rid  in  C_M_AXI_ID_WIDTH  ignored
m_axi_rdata  in  C_M_AXI_DATA_WIDTH  read data
m_axi_rresp  in  2  response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
usr_rd_data  out  C_M_AXI_DATA_WIDTH  forwarded data
usr_rd_valid  out  1  data valid
usr_rd_ready  in  1  consumer ready
usr_rd_last  out  1  final beat of whole command
rd_done  out  1  one-cycle pulse, command complete
rd_err  out  1  sticky error, cleared on next command accept

Behaviour:
- Reset values: arvalid, rready, usr_rd_valid, usr_rd_last, rd_done, rd_err, cmd_ready all 0; araddr=0, arlen=0; state=IDLE. Reset mid-burst abandons the transfer with no drain.
- States: IDLE, ADDR, DATA, DONE.
- IDLE: cmd_ready=1 (forced 0 while m_axi_areset=1).
  - On cmd_valid: latch addr with low log2(bytes) bits cleared and remaining=cmd_len; clear rd_err.
  - cmd_len=0 goes to DONE; otherwise goes to ADDR.
- ADDR:
  - burst = min(remaining, C_MAX_BURST_LEN, (4096 - addr[11:0]) / bytes_per_beat).
  - arvalid=1 with araddr/arlen=burst-1 registered and stable until arready.
  - On arvalid&arready: beat_cnt=burst, remaining-=burst, addr+=burst*bytes; go to DATA. Only one burst is outstanding.
- DATA:
  - Beat transfer on rvalid&rready; beat_cnt decrements on each transfer.
  - rresp≠2'b00 sets rd_err.
  - rlast on a beat with beat_cnt≠1, or beat_cnt=1 without rlast, sets rd_err. The burst ends on the beat_cnt=1 transfer regardless.
  - Burst end: if remaining=0 go to DONE, else go to ADDR (next AR issued the following cycle).
- DONE: rd_done=1 for one cycle, then go to IDLE.
- usr_rd_last=1 on the beat where beat_cnt=1 and remaining=0.
- Arithmetic: remaining is 16-bit; addr wraps modulo 2^C_M_AXI_ADDR_WIDTH without error.
- Back-pressure: usr_rd_ready=0 stalls R indefinitely. No beats are lost or duplicated.

Optional Feature:
MASTERRD_SKID_BUF_EN
- Defined: 2-entry skid buffer between R and usr_rd.
  - usr_rd_* and m_axi_rready are driven from registers; no combinational path from usr_rd_ready to m_axi_rready.
  - Adds 1 cycle of latency.
  - DONE waits until the buffer is empty before pulsing rd_done.
- Undefined: combinational pass-through, zero latency.
  - m_axi_rready = (state==DATA) & usr_rd_ready.
  - usr_rd_valid = (state==DATA) & m_axi_rvalid.
  - usr_rd_data = m_axi_rdata.

Test Plan:
1. cmd_addr=0x1000, cmd_len=4, arready=1 -> one AR with araddr=0x1000, arlen=3; 4 beats forwarded; usr_rd_last on beat 4; rd_done one cycle later; rd_err=0.
2. cmd_addr=0x0FF0, cmd_len=10 (32-bit) -> two ARs: 0x0FF0/arlen=3, then 0x1000/arlen=5; usr_rd_last only on beat 10.
3. cmd_addr=0x2000, cmd_len=40, C_MAX_BURST_LEN=16 -> ARs at 0x2000/15, 0x2040/15, 0x2080/7; 40 beats in order.
4. Random usr_rd_ready toggling and arready held low for 5 cycles -> araddr/arlen stable during the stall; data sequence 0..N-1 intact; no drops.
5. rresp=2'b10 on beat 2 of 4, and separately rlast on beat 3 of 4 -> rd_err=1 in each case; rd_done still pulses; next cmd accept clears rd_err.
6. cmd_len=0 -> no AR, rd_done pulses. Assert reset mid-DATA -> all outputs return to reset values asynchronously, and a new command works.

Source files
------------

// File: rtl/axi4_masterrd_if.sv
// Bus bundle for axi4_masterrd: local command, AXI4 AR/R channels, local read stream
// and status. The master modport is the initiator's view; slave is the environment's view.
interface axi4_masterrd_if #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32
);

  // Local command
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr;
  logic [15:0]                   cmd_len;

  // AXI4 read address channel
  logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid;
  logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]                    m_axi_arlen;
  logic [2:0]                    m_axi_arsize;
  logic [1:0]                    m_axi_arburst;
  logic                          m_axi_arvalid;
  logic                          m_axi_arready;

  // AXI4 read data channel
  logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_rid;
  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]                    m_axi_rresp;
  logic                          m_axi_rlast;
  logic                          m_axi_rvalid;
  logic                          m_axi_rready;

  // Local read stream and status
  logic [C_M_AXI_DATA_WIDTH-1:0] usr_rd_data;
  logic                          usr_rd_valid;
  logic                          usr_rd_ready;
  logic                          usr_rd_last;
  logic                          rd_done;
  logic                          rd_err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len,
    output cmd_ready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output usr_rd_data, usr_rd_valid, usr_rd_last,
    input  usr_rd_ready,
    output rd_done, rd_err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len,
    input  cmd_ready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  usr_rd_data, usr_rd_valid, usr_rd_last,
    output usr_rd_ready,
    input  rd_done, rd_err
  );

endinterface

// File: rtl/axi4_masterrd.sv
// AXI4 read initiator. Splits a local (address, beat count) command into INCR bursts that
// never cross a 4 KB page, issues them one at a time on AR and forwards R beats to a local
// valid/ready stream. Optional macro MASTERRD_SKID_BUF_EN inserts a registered 2-entry skid
// buffer between R and the local stream; by default the R path is a combinational pass-through.
module axi4_masterrd #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_ID         = 0,
  parameter int unsigned C_MAX_BURST_LEN    = 16
) (
  input logic             m_axi_aclk,
  input logic             m_axi_areset,
  axi4_masterrd_if.master bus
);

  localparam int unsigned DW        = C_M_AXI_DATA_WIDTH;
  localparam int unsigned AW        = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned Bytes     = DW / 8;
  localparam int unsigned Lsb       = $clog2(Bytes);
  localparam int unsigned PageBeats = 4096 / Bytes;
  localparam logic [AW-1:0] AddrMask = {{(AW - Lsb){1'b1}}, {Lsb{1'b0}}};

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [8:0]    beat_cnt_q, beat_cnt_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic [7:0]    arlen_q, arlen_d;
  logic          rd_err_q, rd_err_d;

  logic          cmd_ready;
  logic          cmd_fire;
  logic          ar_fire;
  logic          r_fire;
  logic          rready;
  logic          beat_last;
  logic          last_now;
  logic          burst_end;
  logic          buf_empty;
  logic [8:0]    ar_beats;
  logic [AW-1:0] cmd_addr_al;
  logic [AW-1:0] burst_src_addr;
  logic [15:0]   burst_src_rem;
  logic [8:0]    burst_len;

  // Beats that fit: min(remaining, max burst, beats left before the next 4 KB boundary)
  function automatic logic [8:0] calc_burst(input logic [11-Lsb:0] page_idx,
                                            input logic [15:0] rem);
    logic [16:0] room;
    logic [16:0] b;
    room = 17'(PageBeats) - 17'(page_idx);
    b    = {1'b0, rem};
    if (b > room) b = room;
    if (b > 17'(C_MAX_BURST_LEN)) b = 17'(C_MAX_BURST_LEN);
    return 9'(b);
  endfunction

  assign cmd_fire    = bus.cmd_valid & cmd_ready;
  assign ar_fire     = (state_q == StAddr) & bus.m_axi_arready;
  assign r_fire      = bus.m_axi_rvalid & rready;
  assign beat_last   = (beat_cnt_q == 9'd1);
  assign last_now    = beat_last & (remaining_q == 16'd0);
  assign burst_end   = (state_q == StData) & r_fire & beat_last;
  assign ar_beats    = {1'b0, arlen_q} + 9'd1;
  assign cmd_addr_al = bus.cmd_addr & AddrMask;

  // From IDLE the first burst is sized from the incoming command, later ones from state
  assign burst_src_addr = (state_q == StIdle) ? cmd_addr_al  : addr_q;
  assign burst_src_rem  = (state_q == StIdle) ? bus.cmd_len : remaining_q;
  assign burst_len      = calc_burst(burst_src_addr[11:Lsb], burst_src_rem);

  // State and datapath registers
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      rd_err_q    <= rd_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cmd_fire) state_d = (bus.cmd_len == 16'd0) ? StDone : StAddr;
      StAddr: if (bus.m_axi_arready) state_d = StData;
      StData: if (burst_end) state_d = (remaining_q == 16'd0) ? StDone : StAddr;
      StDone: if (buf_empty) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Command latch, AR parameter capture, beat counting and error tracking
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    rd_err_d    = rd_err_q;
    if (cmd_fire) begin
      addr_d      = cmd_addr_al;
      remaining_d = bus.cmd_len;
      rd_err_d    = 1'b0;
    end
    if (ar_fire) begin
      beat_cnt_d  = ar_beats;
      remaining_d = remaining_q - {7'd0, ar_beats};
      addr_d      = addr_q + (AW'(ar_beats) << Lsb);
    end
    if ((state_q == StData) && r_fire) begin
      beat_cnt_d = beat_cnt_q - 9'd1;
      // rlast must coincide exactly with the final counted beat
      if ((bus.m_axi_rresp != 2'b00) || (bus.m_axi_rlast != beat_last)) rd_err_d = 1'b1;
    end
    // AR fields are captured once on entry to ADDR so they hold steady through a stall
    if ((state_d == StAddr) && (state_q != StAddr)) begin
      araddr_d = burst_src_addr;
      arlen_d  = 8'(burst_len - 9'd1);
    end
  end

  // FSM outputs; cmd_ready is masked while reset is asserted
  always_comb begin
    cmd_ready   = (state_q == StIdle) & ~m_axi_areset;
    bus.rd_done = (state_q == StDone) & buf_empty;
  end

  assign bus.cmd_ready     = cmd_ready;
  assign bus.rd_err        = rd_err_q;
  assign bus.m_axi_arid    = C_M_AXI_ID_WIDTH'(C_M_AXI_ID);
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.m_axi_arsize  = 3'(Lsb);
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arvalid = (state_q == StAddr);
  assign bus.m_axi_rready  = rready;

`ifdef MASTERRD_SKID_BUF_EN
  // Entry 0 is the head; each entry holds {last, data}
  logic [DW:0] skid_q [2];
  logic [DW:0] skid_d [2];
  logic [1:0]  cnt_q, cnt_d;
  logic        rready_q, rready_d;
  logic        push;
  logic        pop;
  logic        wr_sel;

  assign push   = r_fire;
  assign pop    = (cnt_q != 2'd0) & bus.usr_rd_ready;
  assign wr_sel = (cnt_q == 2'd1) & ~pop;
  assign rready = rready_q;

  // Skid buffer occupancy and registered R ready
  always_comb begin
    skid_d = skid_q;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    if (pop) skid_d[0] = skid_q[1];
    if (push) skid_d[wr_sel] = {last_now, bus.m_axi_rdata};
    rready_d = (state_d == StData) & (cnt_d != 2'd2);
  end

  // Skid buffer storage
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      skid_q[0] <= '0;
      skid_q[1] <= '0;
      cnt_q     <= '0;
      rready_q  <= 1'b0;
    end else begin
      skid_q    <= skid_d;
      cnt_q     <= cnt_d;
      rready_q  <= rready_d;
    end
  end

  assign buf_empty        = (cnt_q == 2'd0);
  assign bus.usr_rd_valid = (cnt_q != 2'd0);
  assign bus.usr_rd_data  = skid_q[0][DW-1:0];
  assign bus.usr_rd_last  = (cnt_q != 2'd0) & skid_q[0][DW];
`else
  logic usr_valid;

  // Zero-latency pass-through of R to the local stream
  always_comb begin
    usr_valid = (state_q == StData) & bus.m_axi_rvalid;
    rready    = (state_q == StData) & bus.usr_rd_ready;
  end

  assign buf_empty        = 1'b1;
  assign bus.usr_rd_valid = usr_valid;
  assign bus.usr_rd_data  = bus.m_axi_rdata;
  assign bus.usr_rd_last  = usr_valid & last_now;
`endif

  // RID carries no information with a single outstanding burst
  logic unused_rid;
  assign unused_rid = ^bus.m_axi_rid;

endmodule

// File: tb/tb_axi4_masterrd.sv
// Bench for axi4_masterrd: table of commands with expected AR counts and error status, an AXI
// slave model producing address-derived data, and a scoreboard of expected stream beats.
module tb_axi4_masterrd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_masterrd_if #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ID_WIDTH  (1),
    .C_M_AXI_ADDR_WIDTH(32)
  ) bus ();

  axi4_masterrd #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ID_WIDTH  (1),
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_ID        (0),
    .C_MAX_BURST_LEN   (16)
  ) dut (
    .m_axi_aclk  (clk),
    .m_axi_areset(rst),
    .bus         (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          len;
  } burst_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    int          stall;
    bit          rnd;
    int          err;
    int          exp_nar;
    bit          exp_err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  burst_t exp_ar_q[$];
  burst_t br_q[$];
  beat_t  sb_q[$];

  int ar_stall = 0;
  bit rnd      = 1'b0;
  int err_mode = 0;
  int ar_seen  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference split of a command into bursts and stream beats
  task automatic push_expect(input logic [31:0] addr, input int len);
    logic [31:0] a;
    logic [31:0] w;
    int rem, b, room;
    a = addr & ~32'h3;
    for (int k = 0; k < len; k++) begin
      w = ((a >> 2) + 32'(k)) & 32'h3FFF_FFFF;
      sb_q.push_back('{w, (k == len - 1)});
    end
    rem = len;
    while (rem > 0) begin
      b    = (rem > 16) ? 16 : rem;
      room = (4096 - int'(a[11:0])) / 4;
      if (b > room) b = room;
      exp_ar_q.push_back('{a, b - 1});
      a   = a + 32'(b * 4);
      rem = rem - b;
    end
  endtask

  // AR slave: optional per-burst stall, address check and stability check
  logic [31:0] prev_araddr;
  logic [7:0]  prev_arlen;
  int          ar_wait = 0;
  bit          ar_have_prev = 1'b0;
  initial begin
    burst_t e;
    bus.m_axi_arready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_wait      = 0;
        ar_have_prev = 1'b0;
      end else if (bus.m_axi_arvalid) begin
        if (bus.m_axi_arready) begin
          ar_seen++;
          if (exp_ar_q.size() == 0) begin
            chk("ar_unexpected", 64'(bus.m_axi_araddr), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_ar_q.pop_front();
            chk("araddr", 64'(bus.m_axi_araddr), 64'(e.addr));
            chk("arlen", 64'(bus.m_axi_arlen), 64'(e.len));
          end
          br_q.push_back('{bus.m_axi_araddr, int'(bus.m_axi_arlen)});
          ar_wait      = 0;
          ar_have_prev = 1'b0;
        end else begin
          if (ar_have_prev) begin
            chk("araddr_stable", 64'(bus.m_axi_araddr), 64'(prev_araddr));
            chk("arlen_stable", 64'(bus.m_axi_arlen), 64'(prev_arlen));
          end
          prev_araddr  = bus.m_axi_araddr;
          prev_arlen   = bus.m_axi_arlen;
          ar_have_prev = 1'b1;
          ar_wait++;
        end
      end
      @(posedge clk);
      #1;
      bus.m_axi_arready = (ar_wait >= ar_stall);
    end
  end

  // R slave: data word is the beat's word address, with optional error injection
  burst_t cur;
  bit     r_active = 1'b0;
  int     r_beat   = 0;
  initial begin
    bit fired;
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata  = '0;
    bus.m_axi_rlast  = 1'b0;
    bus.m_axi_rresp  = 2'b00;
    bus.m_axi_rid    = '0;
    forever begin
      @(negedge clk);
      fired = 1'b0;
      if (rst) begin
        br_q.delete();
        r_active = 1'b0;
      end else if (bus.m_axi_rvalid && bus.m_axi_rready) begin
        fired = 1'b1;
        r_beat++;
        if (r_beat > cur.len) r_active = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!r_active && br_q.size() > 0) begin
        cur      = br_q.pop_front();
        r_active = 1'b1;
        r_beat   = 0;
      end
      if (rst || !r_active) begin
        bus.m_axi_rvalid = 1'b0;
      end else if (!bus.m_axi_rvalid || fired) begin
        bus.m_axi_rvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.m_axi_rdata  = ((cur.addr >> 2) + 32'(r_beat)) & 32'h3FFF_FFFF;
        bus.m_axi_rlast  = (err_mode == 2 && cur.len == 3) ? (r_beat == 2) : (r_beat == cur.len);
        bus.m_axi_rresp  = (err_mode == 1 && r_beat == 1) ? 2'b10 : 2'b00;
      end
    end
  end

  // Consumer: pops the scoreboard on every accepted stream beat
  initial begin
    beat_t e;
    bus.usr_rd_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.usr_rd_valid && bus.usr_rd_ready) begin
        if (sb_q.size() == 0) begin
          chk("usr_extra_beat", 64'(bus.usr_rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("usr_rd_data", 64'(bus.usr_rd_data), 64'(e.data));
          chk("usr_rd_last", 64'(bus.usr_rd_last), 64'(e.last));
        end
      end
      @(posedge clk);
      #1;
      bus.usr_rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, ".cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
    chk({tag, ".arvalid"}, 64'(bus.m_axi_arvalid), 64'd0);
    chk({tag, ".rready"}, 64'(bus.m_axi_rready), 64'd0);
    chk({tag, ".usr_valid"}, 64'(bus.usr_rd_valid), 64'd0);
    chk({tag, ".usr_last"}, 64'(bus.usr_rd_last), 64'd0);
    chk({tag, ".rd_done"}, 64'(bus.rd_done), 64'd0);
    chk({tag, ".rd_err"}, 64'(bus.rd_err), 64'd0);
    chk({tag, ".araddr"}, 64'(bus.m_axi_araddr), 64'd0);
    chk({tag, ".arlen"}, 64'(bus.m_axi_arlen), 64'd0);
  endtask

  task automatic issue_cmd(input logic [31:0] a, input logic [15:0] l);
    bit ok;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.cmd_ready;
    end
    chk("cmd_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit done;
    int n;
    ar_stall = v.stall;
    rnd      = v.rnd;
    err_mode = v.err;
    ar_seen  = 0;
    push_expect(v.addr, int'(v.len));
    issue_cmd(v.addr, v.len);
    @(negedge clk);
    chk($sformatf("v%0d.err_clear", idx), 64'(bus.rd_err), 64'd0);
    done = 1'b0;
    n    = 0;
    while (!done && n < 3000) begin
      if (bus.rd_done) done = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk($sformatf("v%0d.done_seen", idx), 64'(done), 64'd1);
    if (done) begin
      chk($sformatf("v%0d.rd_err", idx), 64'(bus.rd_err), 64'(v.exp_err));
      chk($sformatf("v%0d.ar_count", idx), 64'(ar_seen), 64'(v.exp_nar));
      chk($sformatf("v%0d.beats_left", idx), 64'(sb_q.size()), 64'd0);
      chk($sformatf("v%0d.ars_left", idx), 64'(exp_ar_q.size()), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d.done_1cyc", idx), 64'(bus.rd_done), 64'd0);
    end
    sb_q.delete();
    exp_ar_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    vec_t post;
    bit   seen;
    vecs[0]  = '{32'h0000_1000, 16'd4,  0, 1'b0, 0, 1, 1'b0};
    vecs[1]  = '{32'h0000_0FF0, 16'd10, 0, 1'b0, 0, 2, 1'b0};
    vecs[2]  = '{32'h0000_2000, 16'd40, 0, 1'b0, 0, 3, 1'b0};
    vecs[3]  = '{32'h0000_3000, 16'd37, 5, 1'b1, 0, 3, 1'b0};
    vecs[4]  = '{32'h0000_4000, 16'd4,  0, 1'b0, 1, 1, 1'b1};
    vecs[5]  = '{32'h0000_5000, 16'd4,  0, 1'b0, 2, 1, 1'b1};
    vecs[6]  = '{32'h0000_0FFC, 16'd3,  0, 1'b0, 0, 2, 1'b0};
    vecs[7]  = '{32'h0000_6002, 16'd2,  0, 1'b0, 0, 1, 1'b0};
    vecs[8]  = '{32'hFFFF_FFF8, 16'd4,  0, 1'b0, 0, 2, 1'b0};
    vecs[9]  = '{32'h0000_7000, 16'd0,  0, 1'b0, 0, 0, 1'b0};
    vecs[10] = '{32'h0000_7000, 16'd20, 2, 1'b1, 0, 2, 1'b0};
    post     = '{32'h0000_9000, 16'd8,  0, 1'b0, 0, 1, 1'b0};

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    rst           = 1'b1;
    #12;
    chk_reset("por");
    chk("arsize", 64'(bus.m_axi_arsize), 64'd2);
    chk("arburst", 64'(bus.m_axi_arburst), 64'd1);
    chk("arid", 64'(bus.m_axi_arid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.cmd_ready", 64'(bus.cmd_ready), 64'd1);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Asynchronous reset while beats are streaming, then recovery
    ar_stall = 0;
    rnd      = 1'b0;
    err_mode = 0;
    push_expect(32'h0000_8000, 16);
    issue_cmd(32'h0000_8000, 16'd16);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (sb_q.size() <= 13);
    end
    chk("mid.beats_flowing", 64'(seen), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("mid");
    sb_q.delete();
    exp_ar_q.delete();
    repeat (3) @(negedge clk);
    chk_reset("hold");
    rst = 1'b0;
    @(negedge clk);
    run_vec(99, post);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
